sr_run_ctrl: RTL and testbench

Run/halt/single-step controller for the schoolRISCV core on the board top. It replaces the free-running slow clock with a clock enable `cpu_en` on the main `clk`, taken from a slow `tick`. The CPU advances one instruction per `cpu_en` pulse. Users control it with two board keys: run/halt toggle and single step. A PC breakpoint halts the core before the matching instruction issues. It also provides a retired-instruction counter for the seven-segment display.

---
 rtl/sr_ctrl_pkg.sv | 12 +
 rtl/sr_key_edge.sv | 51 +++++
 rtl/sr_run_ctrl.sv | 109 ++++++++++
 tb/tb_sr_run_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types for the schoolRISCV run/halt/step controller.
package sr_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

endpackage

// File: rtl/sr_key_edge.sv
// Board key conditioner: 2-flop synchronizer, stability filter and rising-edge pulse.
module sr_key_edge #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             armed;
    logic [1:0]       fill;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            armed <= 1'b0;
            fill  <= '0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            pulse <= 1'b0;
            // A key held through reset is absorbed silently; pulses need a real low first.
            if (fill[1] && !sync2) begin
                armed <= 1'b1;
            end
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                pulse <= sync2 && armed;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sr_run_ctrl.sv
// Run/halt/single-step clock-enable controller with PC breakpoint and retired counter.
module sr_run_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          RUN_ON_RESET    = 1'b1,
    parameter int unsigned W_CNT           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_run,
    input  logic             key_step,
    input  logic             tick,
    input  logic [31:0]      pc,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    output logic             cpu_en,
    output logic             halted,
    output state_t           state,
    output logic [W_CNT-1:0] retired
);

    localparam state_t RESET_STATE = RUN_ON_RESET ? RUN : HALT;

    state_t state_q;
    state_t state_d;
    logic   run_pulse;
    logic   step_pulse;
    logic   bp_skip;
    logic   skip_d;
    logic   bp_hit;
    logic   issue;

    sr_key_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .clk   (clk),
        .rst   (rst),
        .key   (key_run),
        .pulse (run_pulse)
    );

    sr_key_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk   (clk),
        .rst   (rst),
        .key   (key_step),
        .pulse (step_pulse)
    );

    assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip;

    always_comb begin
        state_d = state_q;
        skip_d  = bp_skip;
        issue   = 1'b0;
        case (state_q)
            HALT: begin
                if (run_pulse) begin
                    state_d = RUN;
                    skip_d  = 1'b1;
                end else if (step_pulse) begin
                    state_d = STEP;
                    skip_d  = 1'b1;
                end
            end
            RUN: begin
                if (run_pulse) begin
                    state_d = HALT;
                end else if (tick) begin
                    if (bp_hit) begin
                        state_d = HALT;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            STEP: begin
                issue = tick;
                if (run_pulse) begin
                    state_d = RUN;
                end else if (tick) begin
                    state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase
        if (issue) begin
            skip_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cpu_en  <= 1'b0;
            bp_skip <= 1'b0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            cpu_en  <= issue;
            bp_skip <= skip_d;
            if (cpu_en) begin
                retired <= retired + W_CNT'(1);
            end
        end
    end

    assign state  = state_q;
    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_sr_run_ctrl.sv
// Directed self-checking bench for sr_run_ctrl with a short debounce and 4-bit counter.
module tb_sr_run_ctrl;
    import sr_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_run;
    logic        key_step;
    logic        tick;
    logic [31:0] pc;
    logic        bp_en;
    logic [31:0] bp_addr;

    logic        cpu_en;
    logic        halted;
    state_t      state;
    logic [3:0]  retired;

    logic        cpu_en2;
    logic        halted2;
    state_t      state2;
    logic [31:0] retired2;

    int          tests = 0;
    int          fails = 0;
    logic [3:0]  exp_ret;

    always #5 clk = ~clk;

    sr_run_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_ON_RESET(1'b1), .W_CNT(4)) u_dut (
        .clk(clk), .rst(rst), .key_run(key_run), .key_step(key_step), .tick(tick),
        .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_en(cpu_en), .halted(halted), .state(state), .retired(retired)
    );

    sr_run_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_ON_RESET(1'b0), .W_CNT(32)) u_dut_halt (
        .clk(clk), .rst(rst), .key_run(key_run), .key_step(key_step), .tick(tick),
        .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_en(cpu_en2), .halted(halted2), .state(state2), .retired(retired2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; key_run = 1'b0; key_step = 1'b0; tick = 1'b0;
        pc = '0; bp_en = 1'b0; bp_addr = '0;
        cyc(); cyc();
        tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL reset_cpu_en got=%b exp=0", cpu_en); end
        tests++; if (retired !== 4'd0) begin fails++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        tests++; if (state !== RUN) begin fails++; $display("FAIL reset_state got=%0d exp=1", state); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got=%b exp=0", halted); end
        tests++; if (state2 !== HALT || halted2 !== 1'b1 || retired2 !== 32'd0) begin
            fails++; $display("FAIL reset_halt_variant state=%0d halted=%b retired=%0d exp=0/1/0", state2, halted2, retired2);
        end
        rst = 1'b0;
        idle(3);
        exp_ret = 4'd0;
    endtask

    task automatic test_run();
        int n = 0;
        int n2 = 0;
        for (int i = 0; i < 30; i++) begin
            tick = (i % 3 == 0);
            cyc();
            tests++; if (cpu_en !== tick) begin fails++; $display("FAIL run_issue[%0d] cpu_en=%b exp=%b", i, cpu_en, tick); end
            n += int'(cpu_en);
            n2 += int'(cpu_en2);
        end
        tick = 1'b0;
        cyc(); cyc();
        exp_ret = 4'd10;
        tests++; if (n != 10) begin fails++; $display("FAIL run_count got=%0d exp=10", n); end
        tests++; if (retired !== exp_ret) begin fails++; $display("FAIL run_retired got=%0d exp=%0d", retired, exp_ret); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL run_halted got=%b exp=0", halted); end
        tests++; if (n2 != 0) begin fails++; $display("FAIL halt_variant_issue got=%0d exp=0", n2); end
    endtask

    task automatic test_breakpoint();
        bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h10; tick = 1'b1;
        cyc();
        tick = 1'b0;
        tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL bp_no_issue cpu_en=%b exp=0", cpu_en); end
        tests++; if (state !== HALT || halted !== 1'b1) begin fails++; $display("FAIL bp_halt state=%0d halted=%b exp=0/1", state, halted); end
        cyc(); cyc();
        tests++; if (retired !== exp_ret) begin fails++; $display("FAIL bp_retired got=%0d exp=%0d", retired, exp_ret); end
        key_run = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 6) begin
                tests++; if (state !== HALT) begin fails++; $display("FAIL run_key_early state=%0d exp=0", state); end
            end
            if (k == 7) begin
                tests++; if (state !== RUN) begin fails++; $display("FAIL run_key_latency state=%0d exp=1", state); end
            end
        end
        key_run = 1'b0;
        idle(8);
        tests++; if (state !== RUN) begin fails++; $display("FAIL run_key_release state=%0d exp=1", state); end
        tick = 1'b1;
        cyc();
        tests++; if (cpu_en !== 1'b1) begin fails++; $display("FAIL bp_skip_issue cpu_en=%b exp=1", cpu_en); end
        pc = 32'h14;
        cyc();
        tests++; if (cpu_en !== 1'b1) begin fails++; $display("FAIL bp_next_issue cpu_en=%b exp=1", cpu_en); end
        pc = 32'h10;
        cyc();
        tick = 1'b0;
        tests++; if (cpu_en !== 1'b0 || state !== HALT) begin fails++; $display("FAIL bp_rehit cpu_en=%b state=%0d exp=0/0", cpu_en, state); end
        exp_ret = exp_ret + 4'd2;
        cyc(); cyc();
        tests++; if (retired !== exp_ret) begin fails++; $display("FAIL bp_retired2 got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_step();
        int first_k = 0;
        int pulses = 0;
        pc = 32'h20;
        key_step = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (u_dut.step_pulse === 1'b1) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        key_step = 1'b0;
        tests++; if (first_k != 6 || pulses != 1) begin fails++; $display("FAIL step_pulse_time at=%0d n=%0d exp=6/1", first_k, pulses); end
        tests++; if (state !== STEP) begin fails++; $display("FAIL step_state state=%0d exp=2", state); end
        tick = 1'b1;
        cyc();
        tests++; if (cpu_en !== 1'b1 || state !== HALT) begin fails++; $display("FAIL step_issue cpu_en=%b state=%0d exp=1/0", cpu_en, state); end
        cyc();
        tick = 1'b0;
        tests++; if (cpu_en !== 1'b0 || state !== HALT) begin fails++; $display("FAIL step_second_tick cpu_en=%b state=%0d exp=0/0", cpu_en, state); end
        exp_ret = exp_ret + 4'd1;
        idle(8);
        tests++; if (retired !== exp_ret) begin fails++; $display("FAIL step_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_simultaneous();
        int steps = 0;
        key_run = 1'b1; key_step = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (state === STEP) steps++;
        end
        key_run = 1'b0; key_step = 1'b0;
        tests++; if (state !== RUN || steps != 0) begin fails++; $display("FAIL both_keys state=%0d steps=%0d exp=1/0", state, steps); end
        idle(8);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        tests++; if (cpu_en !== 1'b1) begin fails++; $display("FAIL both_keys_run cpu_en=%b exp=1", cpu_en); end
        exp_ret = exp_ret + 4'd1;
        key_run = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick = (k == 7);
            cyc();
            if (k == 7) begin
                tests++; if (cpu_en !== 1'b0 || state !== HALT) begin fails++; $display("FAIL run_with_tick cpu_en=%b state=%0d exp=0/0", cpu_en, state); end
            end
        end
        tick = 1'b0; key_run = 1'b0;
        idle(8);
        tests++; if (retired !== exp_ret || state !== HALT) begin fails++; $display("FAIL simul_end retired=%0d state=%0d exp=%0d/0", retired, state, exp_ret); end
    endtask

    task automatic test_bounce();
        int rp = 0;
        for (int k = 0; k < 20; k++) begin
            key_run = ((k / 2) % 2 == 0);
            cyc();
            rp += int'(u_dut.run_pulse);
        end
        key_run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            rp += int'(u_dut.run_pulse);
        end
        tests++; if (rp != 0 || state !== HALT) begin fails++; $display("FAIL bounce pulses=%0d state=%0d exp=0/0", rp, state); end
    endtask

    task automatic test_reset_mid_run();
        int sp = 0;
        key_run = 1'b1;
        idle(10);
        key_run = 1'b0;
        idle(8);
        tests++; if (state !== RUN) begin fails++; $display("FAIL prereset_run state=%0d exp=1", state); end
        tick = 1'b1;
        cyc();
        key_run = 1'b1; key_step = 1'b1; rst = 1'b1;
        cyc();
        tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL reset_cancel cpu_en=%b exp=0", cpu_en); end
        rst = 1'b0; tick = 1'b0;
        cyc();
        exp_ret = 4'd0;
        tests++; if (retired !== exp_ret || state !== RUN || halted !== 1'b0) begin
            fails++; $display("FAIL reset_mid retired=%0d state=%0d halted=%b exp=0/1/0", retired, state, halted);
        end
        for (int k = 0; k < 15; k++) begin
            cyc();
            sp += int'(u_dut.run_pulse) + int'(u_dut.step_pulse);
        end
        tests++; if (sp != 0 || state !== RUN) begin fails++; $display("FAIL held_keys pulses=%0d state=%0d exp=0/1", sp, state); end
        key_run = 1'b0; key_step = 1'b0;
        idle(10);
        tests++; if (state !== RUN || retired !== exp_ret) begin fails++; $display("FAIL release_after_reset state=%0d retired=%0d exp=1/0", state, retired); end
    endtask

    task automatic test_back_to_back_wrap();
        int n = 0;
        bp_en = 1'b0;
        tick = 1'b1;
        for (int k = 0; k < 17; k++) begin
            cyc();
            n += int'(cpu_en);
        end
        tick = 1'b0;
        cyc(); cyc();
        exp_ret = 4'd1;
        tests++; if (n != 17) begin fails++; $display("FAIL back_to_back issues=%0d exp=17", n); end
        tests++; if (retired !== exp_ret) begin fails++; $display("FAIL wrap retired=%0d exp=%0d", retired, exp_ret); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run();
        test_breakpoint();
        test_step();
        test_simultaneous();
        test_bounce();
        test_reset_mid_run();
        test_back_to_back_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
